// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two requesters (fetch, memory-access) share one memory port.
// One transaction is outstanding at a time. Ties go to the requester that was
// not granted last. A watchdog counter ends any transaction that the memory
// leaves hanging and reports it with an error flag.
module mem_port_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  // fetch requester (read only)
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_done,
  output logic            if_err,
  // memory-access requester (ma_we = {write, size[1:0]})
  input  logic            ma_req,
  input  logic [XLEN-1:0] ma_addr,
  input  logic [XLEN-1:0] ma_wdata,
  input  logic [2:0]      ma_we,
  output logic [XLEN-1:0] ma_rdata,
  output logic            ma_done,
  output logic            ma_err,
  // shared memory port
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [2:0]      mem_we,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  // pipeline stalls
  output logic            stall_fetch,
  output logic            stall_memoryaccess
);

  // Counter must hold TIMEOUT-1 and is never narrower than 5 bits.
  localparam int CNT_W = (($clog2(TIMEOUT) + 1) > 5) ? ($clog2(TIMEOUT) + 1) : 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             last_ma;   // 1: previous grant went to memory-access
  logic             owner_ma;  // 1: current transaction belongs to memory-access

  logic if_elig;
  logic ma_elig;
  logic pick_ma;
  logic active;
  logic complete;
  logic timeout;
  logic finish;

  // A requester still showing its done pulse is not eligible for a regrant.
  assign if_elig  = if_req & ~if_done;
  assign ma_elig  = ma_req & ~ma_done;
  assign pick_ma  = ma_elig & (~if_elig | ~last_ma);

  // A response only counts once the command has been accepted (or with it).
  assign active   = (state == S_CMD) | (state == S_WAIT);
  assign complete = ((state == S_CMD) & mem_ready & mem_rvalid) |
                    ((state == S_WAIT) & mem_rvalid);
  assign timeout  = active & (cnt == CNT_LAST) & ~complete;
  assign finish   = complete | timeout;

  assign stall_fetch        = if_req & ~if_done;
  assign stall_memoryaccess = ma_req & ~ma_done;

  // Arbitration FSM, watchdog counter and registered memory command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      last_ma   <= 1'b0;
      owner_ma  <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 3'b000;
    end else begin
      case (state)
        S_IDLE: begin
          if (if_elig | ma_elig) begin
            state     <= S_CMD;
            cnt       <= '0;
            mem_req   <= 1'b1;
            owner_ma  <= pick_ma;
            last_ma   <= pick_ma;
            mem_addr  <= pick_ma ? ma_addr : if_addr;
            mem_wdata <= pick_ma ? ma_wdata : '0;
            mem_we    <= pick_ma ? ma_we : 3'b000;
          end
        end
        S_CMD, S_WAIT: begin
          if (finish) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if ((state == S_CMD) && mem_ready) begin
              mem_req <= 1'b0;
              state   <= S_WAIT;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Completion reporting: one-cycle done pulse, rdata/err held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata <= '0;
      if_done  <= 1'b0;
      if_err   <= 1'b0;
      ma_rdata <= '0;
      ma_done  <= 1'b0;
      ma_err   <= 1'b0;
    end else begin
      if_done <= 1'b0;
      ma_done <= 1'b0;
      if (finish) begin
        if (owner_ma) begin
          ma_done  <= 1'b1;
          ma_err   <= timeout;
          // Writes return no data; a timed-out transaction returns zero.
          ma_rdata <= (complete && !mem_we[2]) ? mem_rdata : '0;
        end else begin
          if_done  <= 1'b1;
          if_err   <= timeout;
          if_rdata <= complete ? mem_rdata : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, random transactions
// against a transaction-level model, and hand-written reset/regrant sequences.
module tb_mem_port_arbiter;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic            clk;
  logic            rst;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic [XLEN-1:0] if_rdata;
  logic            if_done;
  logic            if_err;
  logic            ma_req;
  logic [XLEN-1:0] ma_addr;
  logic [XLEN-1:0] ma_wdata;
  logic [2:0]      ma_we;
  logic [XLEN-1:0] ma_rdata;
  logic            ma_done;
  logic            ma_err;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [2:0]      mem_we;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            stall_fetch;
  logic            stall_memoryaccess;

  mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk                (clk),
    .rst                (rst),
    .if_req             (if_req),
    .if_addr            (if_addr),
    .if_rdata           (if_rdata),
    .if_done            (if_done),
    .if_err             (if_err),
    .ma_req             (ma_req),
    .ma_addr            (ma_addr),
    .ma_wdata           (ma_wdata),
    .ma_we              (ma_we),
    .ma_rdata           (ma_rdata),
    .ma_done            (ma_done),
    .ma_err             (ma_err),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_we             (mem_we),
    .mem_ready          (mem_ready),
    .mem_rvalid         (mem_rvalid),
    .mem_rdata          (mem_rdata),
    .stall_fetch        (stall_fetch),
    .stall_memoryaccess (stall_memoryaccess)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          ui;       // fetch requests
    bit          um;       // memory-access requests
    logic [2:0]  we;       // memory-access command
    int          dr;       // cycles from first mem_req to mem_ready
    int          dv;       // cycles from mem_ready to mem_rvalid
    logic [31:0] rd;       // data returned by memory
    bit          exp_ma;   // expected winner is memory-access
    int          exp_lat;  // cycles from request to done
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model state
  bit          m_last_ma;
  logic [31:0] m_if_rd;
  logic [31:0] m_ma_rd;
  bit          m_if_err;
  bit          m_ma_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_last_ma = 1'b0;
    m_if_rd   = '0;
    m_ma_rd   = '0;
    m_if_err  = 1'b0;
    m_ma_err  = 1'b0;
  endtask

  task automatic idle_inputs();
    if_req     = 1'b0;
    if_addr    = '0;
    ma_req     = 1'b0;
    ma_addr    = '0;
    ma_wdata   = '0;
    ma_we      = 3'b000;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  // Assert reset away from any clock edge and check outputs clear at once.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst.mem_req",  mem_req,  0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.mem_we",   mem_we,   0);
    chk("rst.if_rdata", if_rdata, 0);
    chk("rst.ma_rdata", ma_rdata, 0);
    chk("rst.done",     {if_done, ma_done}, 0);
    chk("rst.err",      {if_err, ma_err},   0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One complete transaction, entered and left at a negedge with the DUT idle.
  task automatic run_txn(input string nm, input bit ui, input bit um, input logic [2:0] we,
                         input int dr, input int dv, input logic [31:0] rd,
                         input bit exp_ma, input int exp_lat, input bit exp_err,
                         input logic [31:0] exp_rd);
    logic [31:0] ia;
    logic [31:0] maa;
    logic [31:0] mw;
    int k;
    ia  = $urandom;
    maa = $urandom;
    mw  = $urandom;
    if_req   = ui;
    if_addr  = ia;
    ma_req   = um;
    ma_addr  = maa;
    ma_wdata = mw;
    ma_we    = we;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    chk({nm, ".stall_if_req"}, stall_fetch, ui);
    chk({nm, ".stall_ma_req"}, stall_memoryaccess, um);
    for (int c = 1; c <= exp_lat; c++) begin
      step();
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      k = c - 1;
      if (c == 1) begin
        chk({nm, ".mem_addr"},  mem_addr,  exp_ma ? maa : ia);
        chk({nm, ".mem_wdata"}, mem_wdata, exp_ma ? mw : 32'h0);
        chk({nm, ".mem_we"},    mem_we,    exp_ma ? we : 3'b000);
      end
      if (c == exp_lat) begin
        chk({nm, ".mem_req_end"}, mem_req, 0);
        if (exp_ma) begin
          chk({nm, ".ma_done"},  ma_done,  1);
          chk({nm, ".if_done"},  if_done,  0);
          chk({nm, ".ma_rdata"}, ma_rdata, exp_rd);
          chk({nm, ".ma_err"},   ma_err,   exp_err);
          chk({nm, ".if_rdata_hold"}, if_rdata, m_if_rd);
          chk({nm, ".if_err_hold"},   if_err,   m_if_err);
          chk({nm, ".stall_ma_done"}, stall_memoryaccess, 0);
          chk({nm, ".stall_if_other"}, stall_fetch, ui);
        end else begin
          chk({nm, ".if_done"},  if_done,  1);
          chk({nm, ".ma_done"},  ma_done,  0);
          chk({nm, ".if_rdata"}, if_rdata, exp_rd);
          chk({nm, ".if_err"},   if_err,   exp_err);
          chk({nm, ".ma_rdata_hold"}, ma_rdata, m_ma_rd);
          chk({nm, ".ma_err_hold"},   ma_err,   m_ma_err);
          chk({nm, ".stall_if_done"}, stall_fetch, 0);
          chk({nm, ".stall_ma_other"}, stall_memoryaccess, um);
        end
      end else begin
        chk({nm, ".done_early"}, {if_done, ma_done}, 0);
        chk({nm, ".mem_req"}, mem_req, (k <= dr) ? 1 : 0);
        chk({nm, ".stall_if"}, stall_fetch, ui);
        chk({nm, ".stall_ma"}, stall_memoryaccess, um);
        mem_ready  = (k == dr);
        mem_rvalid = (k == dr + dv);
        mem_rdata  = (k == dr + dv) ? rd : 32'($urandom);
      end
    end
    if_req     = 1'b0;
    ma_req     = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    step();
    chk({nm, ".pulse_len"}, {if_done, ma_done}, 0);
    chk({nm, ".idle_req"},  mem_req, 0);
    m_last_ma = exp_ma;
    if (exp_ma) begin
      m_ma_rd  = exp_rd;
      m_ma_err = exp_err;
    end else begin
      m_if_rd  = exp_rd;
      m_if_err = exp_err;
    end
  endtask

  initial begin
    int sel;
    bit ui;
    bit um;
    bit em;
    bit terr;
    logic [2:0] we;
    int dr;
    int dv;
    int lat;
    logic [31:0] rd;
    logic [31:0] erd;

    rst = 1'b0;
    idle_inputs();
    model_reset();

    // ui um we      dr  dv  rd            ma lat err exp_rd
    vecs[0] = '{1'b1, 1'b0, 3'b010, 0,  0,  32'hDEADBEEF, 1'b0, 2,  1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 3'b110, 0,  0,  32'h11111111, 1'b1, 2,  1'b0, 32'h00000000};
    vecs[2] = '{1'b1, 1'b1, 3'b010, 0,  0,  32'h22222222, 1'b0, 2,  1'b0, 32'h22222222};
    vecs[3] = '{1'b1, 1'b1, 3'b010, 3,  2,  32'h33333333, 1'b1, 7,  1'b0, 32'h33333333};
    vecs[4] = '{1'b0, 1'b1, 3'b110, 20, 0,  32'h44444444, 1'b1, 17, 1'b1, 32'h00000000};
    vecs[5] = '{1'b1, 1'b1, 3'b010, 0,  15, 32'h55555555, 1'b0, 17, 1'b0, 32'h55555555};
    vecs[6] = '{1'b1, 1'b0, 3'b000, 2,  14, 32'h66666666, 1'b0, 17, 1'b1, 32'h00000000};
    vecs[7] = '{1'b0, 1'b1, 3'b001, 1,  1,  32'h77777777, 1'b1, 4,  1'b0, 32'h77777777};
    vecs[8] = '{1'b1, 1'b1, 3'b101, 1,  0,  32'h88888888, 1'b0, 3,  1'b0, 32'h88888888};
    vecs[9] = '{1'b1, 1'b1, 3'b101, 0,  1,  32'h99999999, 1'b1, 3,  1'b0, 32'h00000000};

    #2;
    do_reset();

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].ui, vecs[i].um, vecs[i].we, vecs[i].dr,
              vecs[i].dv, vecs[i].rd, vecs[i].exp_ma, vecs[i].exp_lat, vecs[i].exp_err,
              vecs[i].exp_rd);
    end

    // Random transactions checked against the transaction-level model
    for (int i = 0; i < 40; i++) begin
      sel  = int'($urandom_range(0, 2));
      ui   = (sel != 1);
      um   = (sel != 0);
      we   = 3'($urandom_range(0, 7));
      dr   = (int'($urandom_range(0, 7)) == 0) ? 18 : int'($urandom_range(0, 4));
      dv   = (int'($urandom_range(0, 7)) == 0) ? 16 : int'($urandom_range(0, 4));
      rd   = $urandom;
      em   = um && (!ui || !m_last_ma);
      terr = (dr + dv > TIMEOUT - 1);
      lat  = terr ? TIMEOUT + 1 : dr + dv + 2;
      erd  = (terr || (em && we[2])) ? 32'h0 : rd;
      run_txn($sformatf("rand%0d", i), ui, um, we, dr, dv, rd, em, lat, terr, erd);
    end

    // Both requesters hold req through their done cycle: grants alternate
    // back to back and the one showing done is never regranted that cycle.
    do_reset();
    if_req     = 1'b1;
    if_addr    = 32'h0000_1000;
    ma_req     = 1'b1;
    ma_addr    = 32'h0000_2000;
    ma_we      = 3'b010;
    ma_wdata   = '0;
    mem_ready  = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_0000;
    for (int c = 1; c <= 6; c++) begin
      step();
      if ((c % 2) == 1) begin
        chk($sformatf("hold.c%0d.mem_req", c), mem_req, 1);
        chk($sformatf("hold.c%0d.mem_addr", c), mem_addr,
            ((c % 4) == 1) ? 32'h0000_2000 : 32'h0000_1000);
        chk($sformatf("hold.c%0d.done", c), {if_done, ma_done}, 0);
      end else begin
        chk($sformatf("hold.c%0d.mem_req", c), mem_req, 0);
        chk($sformatf("hold.c%0d.if_done", c), if_done, ((c % 4) == 0) ? 1 : 0);
        chk($sformatf("hold.c%0d.ma_done", c), ma_done, ((c % 4) == 2) ? 1 : 0);
        if ((c % 4) == 0) chk($sformatf("hold.c%0d.if_rdata", c), if_rdata, 32'hCAFE_0000);
        else              chk($sformatf("hold.c%0d.ma_rdata", c), ma_rdata, 32'hCAFE_0000);
      end
    end
    if_req     = 1'b0;
    ma_req     = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    step();
    chk("hold.idle_req", mem_req, 0);

    // Reset while waiting for the read response: everything clears without
    // a clock edge, no done pulse follows, and the next tie goes to MA.
    ma_req  = 1'b1;
    ma_addr = 32'h0000_3000;
    ma_we   = 3'b010;
    step();
    chk("rstw.mem_req", mem_req, 1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("rstw.in_wait_req", mem_req, 0);
    chk("rstw.in_wait_done", ma_done, 0);
    #1;
    rst    = 1'b1;
    ma_req = 1'b0;
    #1;
    chk("rstw.mem_addr", mem_addr, 0);
    chk("rstw.mem_we",   mem_we,   0);
    chk("rstw.ma_rdata", ma_rdata, 0);
    chk("rstw.if_rdata", if_rdata, 0);
    chk("rstw.mem_req",  mem_req,  0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rstw.no_done", {if_done, ma_done}, 0);
      chk("rstw.no_req", mem_req, 0);
    end
    mem_rvalid = 1'b0;
    run_txn("post_rst_tie", 1'b1, 1'b1, 3'b010, 0, 0, 32'h600D_600D, 1'b1, 2, 1'b0,
            32'h600D_600D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
